// File: rtl/dd_timeout_marker.sv
// Marks un-acked packets in [rtx_start, rtx_end) of a circular retransmit window.
// The window is processed CHUNK bits per cycle, so the compare logic does not grow with WIN_SIZE.
module dd_timeout_marker #(
    parameter int unsigned WIN_SIZE  = 64,
    parameter int unsigned SEQ_W     = 32,
    parameter int unsigned CHUNK     = 16,
    parameter int unsigned FLOW_ID_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOW_ID_W-1:0] in_flow_id,
    input  logic                 in_mark_rtx,
    input  logic [SEQ_W-1:0]     in_rtx_start,
    input  logic [SEQ_W-1:0]     in_rtx_end,
    input  logic [SEQ_W-1:0]     in_wnd_start,
    input  logic [$clog2(WIN_SIZE)-1:0] in_wnd_ind,
    input  logic [WIN_SIZE-1:0]  in_acked_wnd,
    input  logic [WIN_SIZE-1:0]  in_rtx_wnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOW_ID_W-1:0] out_flow_id,
    output logic [WIN_SIZE-1:0]  out_rtx_wnd,
    output logic [$clog2(WIN_SIZE+1)-1:0] out_mark_cnt,
    output logic                 out_range_err
);

    localparam int unsigned IND_W  = $clog2(WIN_SIZE);
    localparam int unsigned NCHUNK = WIN_SIZE / CHUNK;
    localparam int unsigned CNT_W  = $clog2(WIN_SIZE + 1);
    localparam int unsigned CHK_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned POP_W  = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic [CHK_W-1:0]    chunk_q;
    logic [IND_W-1:0]    s_ind_q;
    logic [CNT_W-1:0]    len_q;
    logic                en_q;
    logic [WIN_SIZE-1:0] acked_q;
    logic [WIN_SIZE-1:0] rtx_in_q;

    // Accept-cycle range arithmetic, all modulo 2^SEQ_W
    logic [SEQ_W-1:0] off_c;
    logic [SEQ_W-1:0] len_raw_c;
    logic             err_c;
    logic [CNT_W-1:0] len_clip_c;
    logic [IND_W-1:0] s_ind_c;
    logic             en_c;

    always_comb begin
        off_c      = in_rtx_start - in_wnd_start;
        len_raw_c  = in_rtx_end - in_rtx_start;
        err_c      = in_mark_rtx & (off_c >= SEQ_W'(WIN_SIZE));
        len_clip_c = (len_raw_c >= SEQ_W'(WIN_SIZE)) ? CNT_W'(WIN_SIZE) : CNT_W'(len_raw_c);
        s_ind_c    = IND_W'(off_c) + in_wnd_ind;
        en_c       = in_mark_rtx & ~err_c & (len_clip_c != '0);
    end

    // One chunk of the window: modular distance from s_ind decides the hit, so wrap is free
    logic [IND_W-1:0] base_c;
    logic [CHUNK-1:0] acked_chunk_c;
    logic [CHUNK-1:0] rtx_chunk_c;
    logic [CHUNK-1:0] new_chunk_c;
    logic [POP_W-1:0] pop_c;
    logic [IND_W-1:0] dist_c;
    logic             hit_c;
    logic             last_chunk_c;

    always_comb begin
        base_c        = IND_W'(chunk_q) * IND_W'(CHUNK);
        acked_chunk_c = acked_q[base_c +: CHUNK];
        rtx_chunk_c   = rtx_in_q[base_c +: CHUNK];
        new_chunk_c   = '0;
        pop_c         = '0;
        dist_c        = '0;
        hit_c         = 1'b0;
        for (int unsigned j = 0; j < CHUNK; j++) begin
            dist_c         = base_c + IND_W'(j) - s_ind_q;
            hit_c          = en_q & (CNT_W'(dist_c) < len_q);
            new_chunk_c[j] = ~acked_chunk_c[j] & (hit_c | rtx_chunk_c[j]);
            if (new_chunk_c[j] & ~rtx_chunk_c[j]) begin
                pop_c = pop_c + POP_W'(1);
            end
        end
        last_chunk_c = (chunk_q == CHK_W'(NCHUNK - 1));
    end

    logic accept_c;

    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = MARK;
                end
            end
            MARK: begin
                if (last_chunk_c) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Handshake flags track the next state so they stay registered
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_flow_id   <= '0;
            out_rtx_wnd   <= '0;
            out_mark_cnt  <= '0;
            out_range_err <= 1'b0;
            chunk_q       <= '0;
            s_ind_q       <= '0;
            len_q         <= '0;
            en_q          <= 1'b0;
            acked_q       <= '0;
            rtx_in_q      <= '0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == OUT);
            if (accept_c) begin
                chunk_q       <= '0;
                s_ind_q       <= s_ind_c;
                len_q         <= len_clip_c;
                en_q          <= en_c;
                acked_q       <= in_acked_wnd;
                rtx_in_q      <= in_rtx_wnd;
                out_flow_id   <= in_flow_id;
                out_mark_cnt  <= '0;
                out_range_err <= err_c;
            end
            if (state_q == MARK) begin
                out_rtx_wnd[base_c +: CHUNK] <= new_chunk_c;
                out_mark_cnt                 <= out_mark_cnt + CNT_W'(pop_c);
                chunk_q                      <= chunk_q + CHK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dd_timeout_marker.sv
// Directed bench for dd_timeout_marker with a 16-bit window processed 4 bits per cycle.
module tb_dd_timeout_marker;

    localparam int unsigned WIN_SIZE  = 16;
    localparam int unsigned SEQ_W     = 32;
    localparam int unsigned CHUNK     = 4;
    localparam int unsigned FLOW_ID_W = 10;
    localparam int unsigned IND_W     = $clog2(WIN_SIZE);
    localparam int unsigned CNT_W     = $clog2(WIN_SIZE + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [FLOW_ID_W-1:0] in_flow_id;
    logic                 in_mark_rtx;
    logic [SEQ_W-1:0]     in_rtx_start;
    logic [SEQ_W-1:0]     in_rtx_end;
    logic [SEQ_W-1:0]     in_wnd_start;
    logic [IND_W-1:0]     in_wnd_ind;
    logic [WIN_SIZE-1:0]  in_acked_wnd;
    logic [WIN_SIZE-1:0]  in_rtx_wnd;
    logic                 out_valid;
    logic                 out_ready;
    logic [FLOW_ID_W-1:0] out_flow_id;
    logic [WIN_SIZE-1:0]  out_rtx_wnd;
    logic [CNT_W-1:0]     out_mark_cnt;
    logic                 out_range_err;

    int n_checks = 0;
    int n_errors = 0;

    dd_timeout_marker #(
        .WIN_SIZE (WIN_SIZE),
        .SEQ_W    (SEQ_W),
        .CHUNK    (CHUNK),
        .FLOW_ID_W(FLOW_ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_flow_id   (in_flow_id),
        .in_mark_rtx  (in_mark_rtx),
        .in_rtx_start (in_rtx_start),
        .in_rtx_end   (in_rtx_end),
        .in_wnd_start (in_wnd_start),
        .in_wnd_ind   (in_wnd_ind),
        .in_acked_wnd (in_acked_wnd),
        .in_rtx_wnd   (in_rtx_wnd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_flow_id  (out_flow_id),
        .out_rtx_wnd  (out_rtx_wnd),
        .out_mark_cnt (out_mark_cnt),
        .out_range_err(out_range_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_inputs(input logic [FLOW_ID_W-1:0] fid, input logic mark,
                               input logic [SEQ_W-1:0] rstart, input logic [SEQ_W-1:0] rend,
                               input logic [SEQ_W-1:0] wstart, input logic [IND_W-1:0] ind,
                               input logic [WIN_SIZE-1:0] acked, input logic [WIN_SIZE-1:0] rtx);
        in_flow_id   = fid;
        in_mark_rtx  = mark;
        in_rtx_start = rstart;
        in_rtx_end   = rend;
        in_wnd_start = wstart;
        in_wnd_ind   = ind;
        in_acked_wnd = acked;
        in_rtx_wnd   = rtx;
    endtask

    // Presents one event and returns just after the accepting edge
    task automatic send_event(input string tag, input logic [FLOW_ID_W-1:0] fid, input logic mark,
                              input logic [SEQ_W-1:0] rstart, input logic [SEQ_W-1:0] rend,
                              input logic [SEQ_W-1:0] wstart, input logic [IND_W-1:0] ind,
                              input logic [WIN_SIZE-1:0] acked, input logic [WIN_SIZE-1:0] rtx);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check_val({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
        load_inputs(fid, mark, rstart, rend, wstart, ind, acked, rtx);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called just after the accept edge (cycle T+1); out_valid is due in cycle T+5
    task automatic wait_out(input string tag);
        int lat;
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check_val({tag, "_latency"}, 64'(lat), 64'd5);
    endtask

    task automatic check_out(input string tag, input logic [FLOW_ID_W-1:0] fid,
                             input logic [WIN_SIZE-1:0] wnd, input logic [CNT_W-1:0] cnt,
                             input logic err);
        check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_val({tag, "_fid"}, 64'(out_flow_id), 64'(fid));
        check_val({tag, "_wnd"}, 64'(out_rtx_wnd), 64'(wnd));
        check_val({tag, "_cnt"}, 64'(out_mark_cnt), 64'(cnt));
        check_val({tag, "_err"}, 64'(out_range_err), 64'(err));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load_inputs('0, 1'b0, '0, '0, '0, '0, '0, '0);
        tick();
        tick();
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_wnd", 64'(out_rtx_wnd), 64'd0);
        check_val("rst_cnt", 64'(out_mark_cnt), 64'd0);
        check_val("rst_err", 64'(out_range_err), 64'd0);
        check_val("rst_fid", 64'(out_flow_id), 64'd0);
        rst = 1'b0;
        tick();

        // Plain range, bit 3 acked
        send_event("t1", 10'd1, 1'b1, 32'd102, 32'd106, 32'd100, 4'd0, 16'h0008, 16'h0000);
        wait_out("t1");
        check_out("t1", 10'd1, 16'h0034, 5'd3, 1'b0);
        release_out();

        // Range wraps past bit 15
        send_event("t2", 10'd2, 1'b1, 32'd102, 32'd106, 32'd100, 4'd12, 16'h0000, 16'h0001);
        wait_out("t2");
        check_out("t2", 10'd2, 16'hC003, 5'd3, 1'b0);
        release_out();

        // Oversize length clamps to the full window
        send_event("t3a", 10'd3, 1'b1, 32'd100, 32'd200, 32'd100, 4'd0, 16'h00FF, 16'h0000);
        wait_out("t3a");
        check_out("t3a", 10'd3, 16'hFF00, 5'd8, 1'b0);
        release_out();

        // Start beyond window end
        send_event("t3b", 10'd4, 1'b1, 32'd120, 32'd200, 32'd100, 4'd0, 16'h00FF, 16'h1234);
        wait_out("t3b");
        check_out("t3b", 10'd4, 16'h1200, 5'd0, 1'b1);
        release_out();

        // No marking requested
        send_event("t4a", 10'd5, 1'b0, 32'd102, 32'd106, 32'd100, 4'd0, 16'h0003, 16'h0F0F);
        wait_out("t4a");
        check_out("t4a", 10'd5, 16'h0F0C, 5'd0, 1'b0);
        release_out();

        // Empty range
        send_event("t4b", 10'd6, 1'b1, 32'd104, 32'd104, 32'd100, 4'd0, 16'h0003, 16'h0F0F);
        wait_out("t4b");
        check_out("t4b", 10'd6, 16'h0F0C, 5'd0, 1'b0);
        release_out();

        // Backpressure, then back-to-back second event
        send_event("t5a", 10'd7, 1'b1, 32'd102, 32'd106, 32'd100, 4'd0, 16'h0008, 16'h0000);
        wait_out("t5a");
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("t5_hold_valid", 64'(out_valid), 64'd1);
            check_val("t5_hold_ready", 64'(in_ready), 64'd0);
            check_val("t5_hold_wnd", 64'(out_rtx_wnd), 64'h0034);
            check_val("t5_hold_fid", 64'(out_flow_id), 64'd7);
        end
        load_inputs(10'd8, 1'b1, 32'd102, 32'd106, 32'd100, 4'd12, 16'h0000, 16'h0001);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("t5_post_hs_valid", 64'(out_valid), 64'd0);
        check_val("t5_post_hs_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_val("t5_second_accepted", 64'(in_ready), 64'd0);
        wait_out("t5b");
        check_out("t5b", 10'd8, 16'hC003, 5'd3, 1'b0);
        release_out();

        // Reset while chunk 2 is being processed
        send_event("t6a", 10'd9, 1'b1, 32'd102, 32'd106, 32'd100, 4'd0, 16'h0008, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t6_rst_valid", 64'(out_valid), 64'd0);
        check_val("t6_rst_ready", 64'(in_ready), 64'd1);
        begin
            int stale;
            stale = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (out_valid) stale++;
            end
            check_val("t6_no_stale", 64'(stale), 64'd0);
        end
        send_event("t6b", 10'd10, 1'b1, 32'd102, 32'd106, 32'd100, 4'd0, 16'h0008, 16'h0000);
        wait_out("t6b");
        check_out("t6b", 10'd10, 16'h0034, 5'd3, 1'b0);
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
